// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply controller: FSM encoding and default sizing.
package mult_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_WRITE = 2'd2
  } st_e;

  localparam int WIDTH_DEF  = 32;
  localparam int SETTLE_DEF = 4;
endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// Execute-stage / multiplier / HI-LO bus of the multiply controller.
interface mult_hilo_ctrl_if #(parameter int WIDTH = 32);
  logic               start;
  logic               start_rdy;
  logic               op_uns;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_p;
  logic               mthi;
  logic               mtlo;
  logic [WIDTH-1:0]   wdata;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;
  logic               done;

  modport master (
    output start, op_uns, a_in, b_in, mul_p, mthi, mtlo, wdata,
    input  start_rdy, mul_a, mul_b, hi, lo, busy, done
  );

  modport slave (
    input  start, op_uns, a_in, b_in, mul_p, mthi, mtlo, wdata,
    output start_rdy, mul_a, mul_b, hi, lo, busy, done
  );
endinterface

// File: rtl/mult_uns_fix.sv
// Turns the signed array product into the unsigned product (multu).
// Only built when MULT_UNSIGNED_EN is defined.
`ifdef MULT_UNSIGNED_EN
module mult_uns_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] p_i,
  output logic [2*WIDTH-1:0] res_o
);
  logic [2*WIDTH-1:0] corr_a, corr_b;

  // A set MSB means the signed view lost 2^W * other operand; add it back mod 2^(2W).
  always_comb begin
    corr_a = a_i[WIDTH-1] ? {b_i, {WIDTH{1'b0}}} : '0;
    corr_b = b_i[WIDTH-1] ? {a_i, {WIDTH{1'b0}}} : '0;
    res_o  = p_i + corr_a + corr_b;
  end
endmodule
`endif

// File: rtl/mult_hilo_ctrl.sv
// Multicycle front/back end for the external 32x32 array multiplier with MIPS HI/LO.
// Define MULT_UNSIGNED_EN to support multu via the unsigned correction adder.
module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_hilo_ctrl_if.slave bus
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  st_e              state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [2*WIDTH-1:0] result;
  logic busy, done, start_rdy;

`ifdef MULT_UNSIGNED_EN
  logic               uns_q, uns_d;
  logic [2*WIDTH-1:0] fix_p;

  mult_uns_fix #(.WIDTH(WIDTH)) u_fix (
    .a_i  (mul_a_q),
    .b_i  (mul_b_q),
    .p_i  (bus.mul_p),
    .res_o(fix_p)
  );
  assign result = uns_q ? fix_p : bus.mul_p;
`else
  assign result = bus.mul_p;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULT_UNSIGNED_EN
    uns_d     = uns_q;
`endif
    busy      = 1'b0;
    done      = 1'b0;
    start_rdy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_rdy = 1'b1;
        // Moves to HI/LO land first; an accepted multiply overwrites them later.
        if (bus.mthi) hi_d = bus.wdata;
        if (bus.mtlo) lo_d = bus.wdata;
        if (bus.start) begin
          mul_a_d = bus.a_in;
          mul_b_d = bus.b_in;
`ifdef MULT_UNSIGNED_EN
          uns_d   = bus.op_uns;
`endif
          count_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy    = 1'b1;
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy         = 1'b1;
        done         = 1'b1;
        {hi_d, lo_d} = result;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULT_UNSIGNED_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULT_UNSIGNED_EN
      uns_q   <= uns_d;
`endif
    end
  end

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.start_rdy = start_rdy;
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: fixed vectors, corner sequences and randomized multiplies
// against a plain-arithmetic HI/LO model; the array multiplier is modelled alongside.
module tb_mult_hilo_ctrl;
  import mult_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int S = SETTLE_DEF;
`ifdef MULT_UNSIGNED_EN
  localparam bit UNS_EN = 1'b1;
`else
  localparam bit UNS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_hilo_ctrl_if #(.WIDTH(W)) bus();

  // External signed array multiplier
  assign bus.mul_p = $signed({{W{bus.mul_a[W-1]}}, bus.mul_a}) *
                     $signed({{W{bus.mul_b[W-1]}}, bus.mul_b});

  mult_hilo_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    string        nm;
    logic [W-1:0] a, b;
    logic         uns;
    logic [W-1:0] hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start  = 1'b0;
    bus.op_uns = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.wdata  = '0;
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic uns);
    longint pa, pb;
    if (uns && UNS_EN) return {32'h0, a} * {32'h0, b};
    pa = $signed(a);
    pb = $signed(b);
    return 64'(pa * pb);
  endfunction

  // mode: 0 plain, 1 start re-asserted in BUSY, 2 mtlo in BUSY, 3 mthi with start
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                          input int mode, output int bcyc, output int dcnt);
    logic stable;
    logic [W-1:0] lo_before;
    chk("start_rdy_before", {63'h0, bus.start_rdy}, 64'd1);
    lo_before  = m_lo;
    bus.start  = 1'b1;
    bus.a_in   = a;
    bus.b_in   = b;
    bus.op_uns = uns;
    if (mode == 3) begin
      bus.mthi  = 1'b1;
      bus.wdata = 32'hCAFE_F00D;
    end
    step();
    drive_idle();
    if (mode == 3) chk("mthi_with_start", {32'h0, bus.hi}, {32'h0, 32'hCAFE_F00D});
    bcyc = 0;
    dcnt = 0;
    stable = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (!bus.busy) break;
      bcyc++;
      if (bus.done) dcnt++;
      if (bus.mul_a !== a || bus.mul_b !== b) stable = 1'b0;
      if (k == 2 && mode == 2) chk("lo_hold_busy", {32'h0, bus.lo}, {32'h0, lo_before});
      if (k == 1 && mode == 1) begin
        bus.start = 1'b1;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
      end
      if (k == 1 && mode == 2) begin
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h1234_5678;
      end
      step();
      drive_idle();
    end
    chk("busy_timeout", {63'h0, bus.busy}, 64'd0);
    chk("operands_stable", {63'h0, stable}, 64'd1);
  endtask

  task automatic mult_check(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic uns, input int mode);
    int bc, dc;
    logic [63:0] exp;
    exp = ref_prod(a, b, uns);
    run_mult(a, b, uns, mode, bc, dc);
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(S + 1));
    chk({nm, "_done_count"}, 64'(dc), 64'd1);
    chk({nm, "_hilo"}, {bus.hi, bus.lo}, exp);
    {m_hi, m_lo} = exp;
  endtask

  vec_t tv[7];

  initial begin
    int bc, dc;
    logic [W-1:0] ra, rb, rw;
    logic ru;

    tv[0] = '{"m5x7",     32'd5,          32'd7,          1'b0, 32'h0,        32'd35};
    tv[1] = '{"m7xm9",    32'd7,          -32'sd9,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFC1};
    tv[2] = '{"mm9xm34",  -32'sd9,        -32'sd34,       1'b0, 32'h0,        32'd306};
    tv[3] = '{"multu",    32'hFFFF_FFFF,  32'd2,          1'b1,
              UNS_EN ? 32'h1 : 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tv[4] = '{"minxmin",  32'h8000_0000,  32'h8000_0000,  1'b0, 32'h4000_0000, 32'h0};
    tv[5] = '{"maxxmax",  32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1, 32'h3FFF_FFFF, 32'h1};
    tv[6] = '{"zero",     32'h0,          32'hDEAD_BEEF,  1'b0, 32'h0,        32'h0};

    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_hi", {32'h0, bus.hi}, 64'd0);
    chk("rst_lo", {32'h0, bus.lo}, 64'd0);
    chk("rst_busy", {63'h0, bus.busy}, 64'd0);
    chk("rst_done", {63'h0, bus.done}, 64'd0);
    chk("rst_start_rdy", {63'h0, bus.start_rdy}, 64'd1);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle3_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("idle3_busy", {63'h0, bus.busy}, 64'd0);
    chk("idle3_start_rdy", {63'h0, bus.start_rdy}, 64'd1);

    // Table vectors; the -9*-34 entry also re-asserts start during BUSY
    for (int i = 0; i < 7; i++) begin
      run_mult(tv[i].a, tv[i].b, tv[i].uns, (i == 2) ? 1 : 0, bc, dc);
      chk({tv[i].nm, "_busy_cycles"}, 64'(bc), 64'(S + 1));
      chk({tv[i].nm, "_done_count"}, 64'(dc), 64'd1);
      chk({tv[i].nm, "_hi"}, {32'h0, bus.hi}, {32'h0, tv[i].hi});
      chk({tv[i].nm, "_lo"}, {32'h0, bus.lo}, {32'h0, tv[i].lo});
      {m_hi, m_lo} = {tv[i].hi, tv[i].lo};
    end
    step();
    chk("no_requeue_busy", {63'h0, bus.busy}, 64'd0);

    // mthi in IDLE lands on the next edge, lo untouched
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_DEAD;
    step();
    drive_idle();
    chk("mthi_hi", {32'h0, bus.hi}, {32'h0, 32'h0000_DEAD});
    chk("mthi_lo", {32'h0, bus.lo}, {32'h0, m_lo});
    m_hi = 32'h0000_DEAD;

    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hA5A5_0F0F;
    step();
    drive_idle();
    chk("mthilo_both", {bus.hi, bus.lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});
    {m_hi, m_lo} = {32'hA5A5_0F0F, 32'hA5A5_0F0F};

    mult_check("mtlo_in_busy", 32'd1000, 32'd3, 1'b0, 2);
    mult_check("mthi_with_start", -32'sd2, 32'd50, 1'b0, 3);

    // Randomized multiplies interleaved with idle moves, checked against the model
    for (int i = 0; i < 30; i++) begin
      ra = $urandom();
      rb = $urandom();
      ru = 1'($urandom_range(0, 1));
      if (i % 5 == 0) ra = W'($urandom_range(0, 20));
      if (i % 7 == 0) rb = -W'($urandom_range(1, 20));
      mult_check("rand", ra, rb, ru, 0);
      if ($urandom_range(0, 2) == 0) begin
        rw = $urandom();
        bus.mtlo  = 1'b1;
        bus.wdata = rw;
        step();
        drive_idle();
        m_lo = rw;
        chk("rand_mtlo", {bus.hi, bus.lo}, {m_hi, m_lo});
      end
    end

    // Abort a multiply with reset mid-BUSY
    dc = 0;
    bus.start = 1'b1;
    bus.a_in  = 32'd100;
    bus.b_in  = 32'd200;
    step();
    drive_idle();
    repeat (2) begin
      if (bus.done) dc++;
      step();
    end
    chk("abort_in_busy", {63'h0, bus.busy}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort_busy", {63'h0, bus.busy}, 64'd0);
    chk("abort_start_rdy", {63'h0, bus.start_rdy}, 64'd1);
    @(negedge clk);
    if (bus.done) dc++;
    rst_n = 1'b1;
    repeat (S + 2) begin
      step();
      if (bus.done) dc++;
    end
    chk("abort_no_done", 64'(dc), 64'd0);
    chk("abort_hilo_after", {bus.hi, bus.lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    mult_check("after_abort_10x6", 32'd10, 32'd6, 1'b0, 0);
    chk("after_abort_lo", {32'h0, bus.lo}, 64'd60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
